singleportram_be: RTL and testbench
===================================

# singleportram_be

Single-port block RAM with per-byte write enables, read-enable gating, selectable read latency, and selectable read-during-write behaviour. It is the next generation of the team's single-port RAM for synthesized array storage and keeps the same port-B naming and `length` reporting. It adds a `valid_b` read strobe and an optional post-reset zero-fill engine, so generated code can rely on known-zero arrays.

## Interface
- `WIDTH`, default 32: data width in bits. Must be a multiple of 8.
- `DEPTH`, default 10: number of address bits used from `address_b`.
- `WORDS`, default 1024: number of storage words. Must satisfy WORDS ≤ 2^DEPTH.
- `RD_LATENCY`, default 1: read latency in cycles. Legal values are 1 and 2.
- `RDW_MODE`, default 0: read-during-write behaviour. 0 = read-first (old data); 1 = write-first (new merged data).

Ports:
- `clk`  in  1  the single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `length`  out  32  constant WORDS.
- `address_b`  in  32  word address; only bits [DEPTH-1:0] are used.
- `din_b`  in  WIDTH  write data.
- `be_b`  in  WIDTH/8  byte enables; bit i selects `din_b[8i+7:8i]`.
- `we_b`  in  1  write request.
- `oe_b`  in  1  read request.
- `dout_b`  out  WIDTH  read data.
- `valid_b`  out  1  one-cycle pulse marking new `dout_b` data.
- `busy`  out  1  clear in progress; requests are ignored while high.

## Operation
- **Accepted write:** `we_b`=1, `busy`=0, and address < WORDS. Only the bytes with `be_b[i]`=1 are written. `be_b`=0 writes nothing.
- **Accepted read:** `oe_b`=1 and `busy`=0. When `oe_b`=0, `dout_b` holds its last value and `valid_b` stays 0.
- **Out-of-range address (≥ WORDS):** the write is dropped. A read still produces `valid_b`, with `dout_b`=0.
- **Simultaneous read and write, same address:**
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the pre-write word with the enabled bytes replaced by `din_b`.
- **Clear FSM** (present only with the macro):
  - States: CLEAR, READY.
  - `reset` forces state CLEAR with clear address = 0.
  - Each cycle in CLEAR with `reset`=0 writes 0 to the clear address and increments it.
  - After address WORDS-1 is written, the FSM moves to READY.
  - READY is held until the next `reset`.
  - `busy` = (state == CLEAR).
- **Reset mid-clear:** the clear restarts from address 0.
- **Reset values:** `dout_b`=0, `valid_b`=0, all pipeline stages cleared, `busy`=1 (with macro) or 0 (without). Reset does not modify memory contents except through the clear FSM.

## Timing
- **Read latency.** For a read accepted at edge N:
  - RD_LATENCY=1: `dout_b` and `valid_b`=1 appear after edge N+1.
  - RD_LATENCY=2: they appear after edge N+2.
- **Pipelining:** back-to-back reads are accepted every cycle. Each read yields one `valid_b` pulse, in order.
- **Write visibility:** a write at edge N is visible to a different-cycle read accepted at edge N+1 or later.
- **Clear timing:** `reset` is sampled high at edge E0. Clear writes occur at edges E1..E_WORDS. `busy` falls after edge E_WORDS, so the first request can be accepted at edge E_WORDS+1.
- **In-flight reads across reset:** `reset` asserted with reads in flight discards them; no `valid_b` is produced for them.
- **Bounded indices:** the clear counter is DEPTH+1 bits wide and never wraps.

## Configuration
- `SINGLEPORTRAM_BE_CLEAR_EN`
  - **Defined:** the clear FSM is compiled in. Memory is all-zero once `busy` falls, and `busy` behaves as described above.
  - **Undefined:** no FSM is built and `busy` is tied to 0. Accesses are accepted from the first cycle after `reset`. Memory contents are undefined until written.

## Test plan
- **Clear (macro defined, WORDS=16):**
  - Stimulus: pulse `reset` for 1 cycle.
  - Required: `busy`=1 for 16 cycles. Reads of addresses 0..15 then return 0x00000000 with a `valid_b` pulse for each.
- **Byte enables:**
  - Stimulus: write 0xAABBCCDD to address 5 with `be_b`=4'hF, then write 0x11223344 with `be_b`=4'b0101, then read address 5.
  - Required: 0xAA22CC44.
- **Read-during-write:**
  - Stimulus: address 7 holds 0x12345678; issue a same-cycle write of 0xFFFFFFFF (`be_b`=4'hF) and read of address 7.
  - Required: RDW_MODE=0 returns 0x12345678; RDW_MODE=1 returns 0xFFFFFFFF.
- **Latency and streaming (RD_LATENCY=2):**
  - Stimulus: read addresses 0,1,2,3 on consecutive cycles, preloaded with 10,11,12,13.
  - Required: `valid_b` is high for 4 consecutive cycles starting 2 cycles after the first request, with data 10,11,12,13 in order.
- **Reset mid-clear (WORDS=16):**
  - Stimulus: assert `reset` after 8 clear cycles.
  - Required: `busy` stays high for a full 16 further cycles.
- **Gating and range (WORDS=1000, DEPTH=10):**
  - Requests with `busy`=1 or `oe_b`=0 produce no `valid_b`.
  - A write to address 1020 is dropped, and a read of 1020 returns 0 with `valid_b`=1.
  - Address 0 is unchanged after a write to address 1024 (wraps to 0 in bits [9:0]) issued while `busy`=1.

Source files
------------

// File: rtl/singleportram_be.sv
// Single-port RAM with per-byte write enables, 1- or 2-cycle read latency and
// selectable read-during-write. Define SINGLEPORTRAM_BE_CLEAR_EN for post-reset zero-fill.
module singleportram_be #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned WORDS      = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        length,
  input  logic [31:0]        address_b,
  input  logic [WIDTH-1:0]   din_b,
  input  logic [WIDTH/8-1:0] be_b,
  input  logic               we_b,
  input  logic               oe_b,
  output logic [WIDTH-1:0]   dout_b,
  output logic               valid_b,
  output logic               busy
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW = DEPTH + 1;

  logic [WIDTH-1:0] r_mem [WORDS];

  logic [DEPTH-1:0] w_addr;
  logic             w_in_range;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_busy;
  logic             w_clr_we;
  logic [CW-1:0]    w_clr_addr;
  logic             w_unused;

  assign length     = 32'(WORDS);
  assign w_addr     = address_b[DEPTH-1:0];
  assign w_unused   = ^address_b[31:DEPTH];
  assign w_in_range = CW'(w_addr) < CW'(WORDS);
  assign w_wr_acc   = we_b & ~w_busy & ~reset & w_in_range;
  assign w_rd_acc   = oe_b & ~w_busy & ~reset;
  assign busy       = w_busy;

`ifdef SINGLEPORTRAM_BE_CLEAR_EN
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [CW-1:0] r_clr_addr;
  logic [CW-1:0] w_clr_addr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Zero one word per cycle; the counter stops at WORDS and never wraps.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_we       = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we       = ~reset;
        w_clr_addr_nxt = r_clr_addr + CW'(1);
        if (r_clr_addr == CW'(WORDS - 1)) begin
          w_state_nxt = S_READY;
        end
      end
      default: begin
        w_state_nxt = S_READY;
      end
    endcase
  end

  assign w_busy     = (r_state == S_CLEAR);
  assign w_clr_addr = r_clr_addr;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  logic [AW-1:0]    w_mem_idx;
  logic [NB-1:0]    w_mem_be;
  logic [WIDTH-1:0] w_mem_din;
  logic [WIDTH-1:0] w_mem_old;
  logic [WIDTH-1:0] w_mem_merged;

  assign w_mem_idx = w_clr_we ? AW'(w_clr_addr) : AW'(w_addr);
  assign w_mem_be  = w_clr_we ? '1 : (w_wr_acc ? be_b : '0);
  assign w_mem_din = w_clr_we ? '0 : din_b;
  assign w_mem_old = r_mem[w_mem_idx];

  // Byte-merged word; doubles as the write-first read data for user writes.
  always_comb begin
    w_mem_merged = w_mem_old;
    for (int i = 0; i < NB; i++) begin
      if (w_mem_be[i]) begin
        w_mem_merged[8*i +: 8] = w_mem_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (|w_mem_be) begin
      r_mem[w_mem_idx] <= w_mem_merged;
    end
  end

  logic [WIDTH-1:0] w_rd_word;

  always_comb begin
    w_rd_word = '0;
    if (w_in_range) begin
      w_rd_word = w_mem_old;
      if ((RDW_MODE != 0) && w_wr_acc) begin
        w_rd_word = w_mem_merged;
      end
    end
  end

  logic [RD_LATENCY-1:0][WIDTH-1:0] r_pipe_data;
  logic [RD_LATENCY-1:0]            r_pipe_vld;

  // Stage 0 captures the array word; later stages delay it; dout_b holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_data <= '0;
      r_pipe_vld  <= '0;
      dout_b      <= '0;
      valid_b     <= 1'b0;
    end else begin
      r_pipe_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_pipe_data[0] <= w_rd_word;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_pipe_vld[k]  <= r_pipe_vld[k-1];
        r_pipe_data[k] <= r_pipe_data[k-1];
      end
      valid_b <= r_pipe_vld[RD_LATENCY-1];
      if (r_pipe_vld[RD_LATENCY-1]) begin
        dout_b <= r_pipe_data[RD_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_singleportram_be.sv
// Directed bench: two instances (read-first, latency 1, 1000 words; write-first,
// latency 2, 16 words) driven by shared stimulus on the falling edge.
`timescale 1ns/1ps
module tb_singleportram_be;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_b;
  logic [31:0] din_b;
  logic [3:0]  be_b;
  logic        we_b;
  logic        oe_b;

  logic [31:0] len0, len1, dout0, dout1;
  logic        vld0, vld1, busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  int w;

  logic [31:0] rd_addr [16];
  logic [31:0] rd_exp0 [16];
  logic [31:0] rd_exp1 [16];

`ifdef SINGLEPORTRAM_BE_CLEAR_EN
  localparam logic [31:0] BUSY_RST = 32'd1;
  localparam logic [31:0] EXP5_AFTER_RST = 32'h0000_0000;
`else
  localparam logic [31:0] BUSY_RST = 32'd0;
  localparam logic [31:0] EXP5_AFTER_RST = 32'hAA22_CC44;
`endif

  always #5 clk = ~clk;

  singleportram_be #(
    .WIDTH(32), .DEPTH(10), .WORDS(1000), .RD_LATENCY(1), .RDW_MODE(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .length(len0), .address_b(address_b),
    .din_b(din_b), .be_b(be_b), .we_b(we_b), .oe_b(oe_b),
    .dout_b(dout0), .valid_b(vld0), .busy(busy0)
  );

  singleportram_be #(
    .WIDTH(32), .DEPTH(4), .WORDS(16), .RD_LATENCY(2), .RDW_MODE(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .length(len1), .address_b(address_b),
    .din_b(din_b), .be_b(be_b), .we_b(we_b), .oe_b(oe_b),
    .dout_b(dout1), .valid_b(vld1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    address_b = a; din_b = d; be_b = b; we_b = 1'b1;
    @(negedge clk);
    we_b = 1'b0; be_b = 4'h0;
  endtask

  // Read i is driven at step i; dut0 shows it at step i+2, dut1 at step i+3.
  task automatic run_reads(input string tag, input int n);
    for (int k = 0; k < n + 4; k++) begin
      check({tag, "_v0"}, 32'(vld0), 32'(k >= 2 && k < n + 2));
      check({tag, "_v1"}, 32'(vld1), 32'(k >= 3 && k < n + 3));
      if (k >= 2 && k < n + 2) check({tag, "_d0"}, dout0, rd_exp0[k-2]);
      if (k >= 3 && k < n + 3) check({tag, "_d1"}, dout1, rd_exp1[k-3]);
      if (k < n) begin
        oe_b = 1'b1; address_b = rd_addr[k];
      end else begin
        oe_b = 1'b0; address_b = 32'h0;
      end
      @(negedge clk);
    end
  endtask

  task automatic read1(input string tag, input logic [31:0] a,
                       input logic [31:0] e0, input logic [31:0] e1);
    rd_addr[0] = a; rd_exp0[0] = e0; rd_exp1[0] = e1;
    run_reads(tag, 1);
  endtask

  task automatic rdw(input string tag, input logic [31:0] d, input logic [3:0] b,
                     input logic [31:0] e0, input logic [31:0] e1);
    address_b = 32'd7; din_b = d; be_b = b; we_b = 1'b1; oe_b = 1'b1;
    @(negedge clk);
    we_b = 1'b0; oe_b = 1'b0; be_b = 4'h0;
    @(negedge clk);
    check({tag, "_v0"}, 32'(vld0), 32'd1);
    check({tag, "_d0"}, dout0, e0);
    @(negedge clk);
    check({tag, "_v1"}, 32'(vld1), 32'd1);
    check({tag, "_d1"}, dout1, e1);
    check({tag, "_v0_off"}, 32'(vld0), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    w = 0;
    while ((busy0 === 1'b1 || busy1 === 1'b1) && w < 1100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_busy0"}, 32'(busy0), 32'd0);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address_b = '0; din_b = '0; be_b = '0; we_b = 1'b0; oe_b = 1'b0;
    @(negedge clk);
    check("rst_dout0", dout0, 32'd0);
    check("rst_dout1", dout1, 32'd0);
    check("rst_vld0", 32'(vld0), 32'd0);
    check("rst_vld1", 32'(vld1), 32'd0);
    check("rst_busy0", 32'(busy0), BUSY_RST);
    check("rst_busy1", 32'(busy1), BUSY_RST);
    check("length0", len0, 32'd1000);
    check("length1", len1, 32'd16);
    reset = 1'b0;

`ifdef SINGLEPORTRAM_BE_CLEAR_EN
    // Requests issued while clearing must be ignored (address 1024 aliases 0).
    cnt = 0;
    while (busy1 === 1'b1 && cnt < 40) begin
      check("gate_v0", 32'(vld0), 32'd0);
      check("gate_v1", 32'(vld1), 32'd0);
      if (cnt >= 2 && cnt <= 4) begin
        we_b = 1'b1; oe_b = 1'b1; address_b = 32'd1024; din_b = 32'h55; be_b = 4'hF;
      end else begin
        we_b = 1'b0; oe_b = 1'b0; be_b = 4'h0; address_b = 32'h0;
      end
      @(negedge clk);
      cnt++;
    end
    check("clr_busy_len", 32'(cnt), 32'd16);
    check("busy0_still", 32'(busy0), 32'd1);
    wait_ready("clr");
    for (int i = 0; i < 16; i++) begin
      rd_addr[i] = 32'(i); rd_exp0[i] = 32'h0; rd_exp1[i] = 32'h0;
    end
    run_reads("clr_zero", 16);
`endif

    wr(32'd5, 32'hAABB_CCDD, 4'hF);
    wr(32'd5, 32'h1122_3344, 4'b0101);
    read1("be_merge", 32'd5, 32'hAA22_CC44, 32'hAA22_CC44);

    wr(32'd7, 32'h1234_5678, 4'hF);
    rdw("rdw_full", 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 32'hFFFF_FFFF);
    rdw("rdw_part", 32'h0000_0000, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_0000);

    for (int i = 0; i < 4; i++) wr(32'(i), 32'(10 + i), 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd_addr[i] = 32'(i); rd_exp0[i] = 32'(10 + i); rd_exp1[i] = 32'(10 + i);
    end
    run_reads("stream", 4);
    repeat (3) @(negedge clk);
    check("hold_d0", dout0, 32'd13);
    check("hold_d1", dout1, 32'd13);
    check("hold_v0", 32'(vld0), 32'd0);
    check("hold_v1", 32'(vld1), 32'd0);

    wr(32'd5, 32'h0000_0000, 4'h0);
    read1("be_zero", 32'd5, 32'hAA22_CC44, 32'hAA22_CC44);

    // Reads in flight when reset arrives must not produce valid_b.
    address_b = 32'd5; oe_b = 1'b1;
    @(negedge clk);
    oe_b = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rstfl_v0", 32'(vld0), 32'd0);
    check("rstfl_v1", 32'(vld1), 32'd0);
    check("rstfl_d0", dout0, 32'd0);
    check("rstfl_d1", dout1, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rstfl_v0b", 32'(vld0), 32'd0);
    check("rstfl_v1b", 32'(vld1), 32'd0);
    @(negedge clk);
    check("rstfl_v1c", 32'(vld1), 32'd0);
    wait_ready("rstfl");
    read1("after_rst", 32'd5, EXP5_AFTER_RST, EXP5_AFTER_RST);

    // dut0 drops the out-of-range write; dut1 sees address 12.
    wr(32'd1020, 32'hDEAD_BEEF, 4'hF);
    read1("range", 32'd1020, 32'h0000_0000, 32'hDEAD_BEEF);

`ifdef SINGLEPORTRAM_BE_CLEAR_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (busy1 === 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("midclr_busy_len", 32'(cnt), 32'd16);
    wait_ready("midclr");
    read1("midclr_zero", 32'd12, 32'h0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
